// File: rtl/condicionador_pkg.sv
// Shared types and default constants for the push-button conditioner.
package condicionador_pkg;

    localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 50000;
    localparam int unsigned CONTAGEM_LARG          = 8;

    typedef enum logic [1:0] {
        SOLTO            = 2'd0,
        CONFIRMA_PRESS   = 2'd1,
        PRESSIONADO      = 2'd2,
        CONFIRMA_SOLTURA = 2'd3
    } estado_t;

endpackage

// File: rtl/condicionador_botao_sincronizador.sv
// Two-flop synchronizer for the raw key pin; reset loads the released level.
module sincronizador #(
    parameter bit VALOR_RESET = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= VALOR_RESET;
            q    <= VALOR_RESET;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/condicionador_botao.sv
// Debounces a raw key, emits one pulse per confirmed press and counts presses.
module condicionador_botao
    import condicionador_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
    parameter bit          ATIVO_BAIXO     = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     botao_bruto,
    output logic                     pulso,
    output logic                     nivel,
    output logic [CONTAGEM_LARG-1:0] contagem
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

    estado_t          estado;
    logic [CNT_W-1:0] cnt;
    logic             bruto_sinc;
    logic             p;

    sincronizador #(
        .VALOR_RESET (ATIVO_BAIXO)
    ) u_sincronizador (
        .clock (clock),
        .reset (reset),
        .d     (botao_bruto),
        .q     (bruto_sinc)
    );

    // Normalise to active-high "pressed".
    assign p = ATIVO_BAIXO ? ~bruto_sinc : bruto_sinc;

    // Debounce FSM; the counter is cleared on every state change so it never passes CNT_MAX.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= SOLTO;
            cnt      <= '0;
            pulso    <= 1'b0;
            nivel    <= 1'b0;
            contagem <= '0;
        end else begin
            pulso <= 1'b0;
            case (estado)
                SOLTO: begin
                    if (p) begin
                        estado <= CONFIRMA_PRESS;
                        cnt    <= '0;
                    end
                end
                CONFIRMA_PRESS: begin
                    if (!p) begin
                        estado <= SOLTO;
                        cnt    <= '0;
                    end else if (cnt == CNT_MAX) begin
                        estado   <= PRESSIONADO;
                        cnt      <= '0;
                        pulso    <= 1'b1;
                        nivel    <= 1'b1;
                        contagem <= contagem + CONTAGEM_LARG'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSIONADO: begin
                    if (!p) begin
                        estado <= CONFIRMA_SOLTURA;
                        cnt    <= '0;
                    end
                end
                CONFIRMA_SOLTURA: begin
                    if (p) begin
                        estado <= PRESSIONADO;
                        cnt    <= '0;
                    end else if (cnt == CNT_MAX) begin
                        estado <= SOLTO;
                        cnt    <= '0;
                        nivel  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    estado <= SOLTO;
                    cnt    <= '0;
                    nivel  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_condicionador_botao.sv
// Directed bench for condicionador_botao with DEBOUNCE_CICLOS=4, both polarities.
module tb_condicionador_botao;

    logic       clock;
    logic       reset_a, reset_b;
    logic       bruto_a, bruto_b;
    logic       pulso_a, pulso_b;
    logic       nivel_a, nivel_b;
    logic [7:0] contagem_a, contagem_b;

    int checks = 0;
    int errors = 0;
    int n_pulsos_a = 0;
    int n_pulsos_b = 0;
    int colados = 0;
    logic pulso_a_ant = 1'b0;

    condicionador_botao #(.DEBOUNCE_CICLOS(4), .ATIVO_BAIXO(1'b1)) dut_a (
        .clock       (clock),
        .reset       (reset_a),
        .botao_bruto (bruto_a),
        .pulso       (pulso_a),
        .nivel       (nivel_a),
        .contagem    (contagem_a)
    );

    condicionador_botao #(.DEBOUNCE_CICLOS(4), .ATIVO_BAIXO(1'b0)) dut_b (
        .clock       (clock),
        .reset       (reset_b),
        .botao_bruto (bruto_b),
        .pulso       (pulso_b),
        .nivel       (nivel_b),
        .contagem    (contagem_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pulso_a) n_pulsos_a++;
        if (pulso_b) n_pulsos_b++;
        if (pulso_a && pulso_a_ant) colados++;
        pulso_a_ant = pulso_a;
    end

    task automatic checar(input string tag, input int obs, input int esp);
        checks++;
        if (obs != esp) begin
            errors++;
            $display("FAIL %s obs=%0d esp=%0d", tag, obs, esp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic zera_a();
        bruto_a = 1'b1;
        reset_a = 1'b1;
        tick();
        tick();
        reset_a = 1'b0;
    endtask

    initial begin
        int base;
        logic padrao [0:4];

        reset_a = 1'b1;
        reset_b = 1'b1;
        bruto_a = 1'b1;
        bruto_b = 1'b0;
        tick();
        tick();

        // Reset state
        checar("reset_pulso", int'(pulso_a), 0);
        checar("reset_nivel", int'(nivel_a), 0);
        checar("reset_contagem", int'(contagem_a), 0);
        reset_a = 1'b0;
        tick();
        tick();

        // Clean press: pulse exactly after edge 7, level from edge 7 on
        base = n_pulsos_a;
        bruto_a = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            checar($sformatf("limpo_pulso_e%0d", e), int'(pulso_a), (e == 7) ? 1 : 0);
            checar($sformatf("limpo_nivel_e%0d", e), int'(nivel_a), (e >= 7) ? 1 : 0);
        end
        checar("limpo_contagem", int'(contagem_a), 1);
        checar("limpo_n_pulsos", n_pulsos_a - base, 1);

        // Release: no pulse, level falls after edge 7
        bruto_a = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checar($sformatf("solta_pulso_e%0d", e), int'(pulso_a), 0);
            checar($sformatf("solta_nivel_e%0d", e), int'(nivel_a), (e < 7) ? 1 : 0);
        end

        // Bounce: low 2, high 1, low 2, then high
        zera_a();
        padrao[0] = 1'b0; padrao[1] = 1'b0; padrao[2] = 1'b1;
        padrao[3] = 1'b0; padrao[4] = 1'b0;
        for (int e = 0; e < 14; e++) begin
            bruto_a = (e < 5) ? padrao[e] : 1'b1;
            tick();
            checar($sformatf("quique_pulso_e%0d", e), int'(pulso_a), 0);
        end
        checar("quique_nivel", int'(nivel_a), 0);
        checar("quique_contagem", int'(contagem_a), 0);

        // Hold with a one-cycle glitch, then release
        zera_a();
        base = n_pulsos_a;
        bruto_a = 1'b0;
        for (int e = 0; e < 10; e++) tick();
        bruto_a = 1'b1;
        tick();
        bruto_a = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checar($sformatf("glitch_nivel_e%0d", e), int'(nivel_a), 1);
            checar($sformatf("glitch_pulso_e%0d", e), int'(pulso_a), 0);
        end
        bruto_a = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checar($sformatf("glitch_solta_nivel_e%0d", e), int'(nivel_a), (e < 7) ? 1 : 0);
        end
        checar("glitch_n_pulsos", n_pulsos_a - base, 1);
        checar("glitch_contagem", int'(contagem_a), 1);

        // Wrap: 256 press/release round trips
        zera_a();
        base = n_pulsos_a;
        for (int i = 0; i < 256; i++) begin
            bruto_a = 1'b0;
            for (int e = 0; e < 9; e++) tick();
            bruto_a = 1'b1;
            for (int e = 0; e < 9; e++) tick();
            if (i == 254) checar("wrap_contagem_255", int'(contagem_a), 255);
        end
        checar("wrap_contagem_0", int'(contagem_a), 0);
        checar("wrap_n_pulsos", n_pulsos_a - base, 256);
        checar("wrap_colados", colados, 0);

        // Reset at edge 5 of a press with the key held
        zera_a();
        base = n_pulsos_a;
        bruto_a = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checar($sformatf("rstmeio_pulso_e%0d", e), int'(pulso_a), 0);
        end
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        checar("rstmeio_pulso_e5", int'(pulso_a), 0);
        checar("rstmeio_contagem_e5", int'(contagem_a), 0);
        for (int e = 1; e <= 10; e++) begin
            tick();
            checar($sformatf("rstmeio_pos_pulso_e%0d", e), int'(pulso_a), (e == 7) ? 1 : 0);
        end
        checar("rstmeio_contagem", int'(contagem_a), 1);
        checar("rstmeio_n_pulsos", n_pulsos_a - base, 1);

        // Active-high polarity: 0->1 held
        reset_b = 1'b0;
        tick();
        base = n_pulsos_b;
        bruto_b = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checar($sformatf("pol_pulso_e%0d", e), int'(pulso_b), (e == 7) ? 1 : 0);
        end
        checar("pol_nivel", int'(nivel_b), 1);
        checar("pol_contagem", int'(contagem_b), 1);
        checar("pol_n_pulsos", n_pulsos_b - base, 1);

        // Inverted stimulus (1->0 held) on the active-high instance
        bruto_b = 1'b1;
        reset_b = 1'b1;
        tick();
        tick();
        base = n_pulsos_b;
        reset_b = 1'b0;
        bruto_b = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checar($sformatf("inv_pulso_e%0d", e), int'(pulso_b), 0);
        end
        checar("inv_nivel", int'(nivel_b), 0);
        checar("inv_n_pulsos", n_pulsos_b - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/condicionador_botao.md
CONDICIONADOR_BOTAO -- requirements
Module: condicionador_botao

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DEBOUNCE_CICLOS SHALL default to 50000 and SHALL give the number of stable cycles needed to confirm a press or release; legal range is >= 2.
REQ-003 Parameter ATIVO_BAIXO SHALL default to 1; 1 means raw input low = pressed, 0 means raw input high = pressed.
REQ-004 Port clock SHALL be an input, 1 bit, the system clock.
REQ-005 Port reset SHALL be an input, 1 bit, the synchronous active-high reset.
REQ-006 Port botao_bruto SHALL be an input, 1 bit, the raw asynchronous key pin.
REQ-007 Port pulso SHALL be an output, 1 bit, high for exactly one cycle per confirmed press; it drives the downstream toggle FSM's button input.
REQ-008 Port nivel SHALL be an output, 1 bit, the debounced pressed level.
REQ-009 Port contagem SHALL be an output, 8 bits, the count of confirmed presses.

Function
REQ-010 botao_bruto SHALL pass through a 2-flop synchronizer, then be normalised to active-high "pressed" (p) according to ATIVO_BAIXO.
REQ-011 The FSM SHALL have four states: SOLTO, CONFIRMA_PRESS, PRESSIONADO, CONFIRMA_SOLTURA.
REQ-012 In SOLTO, p=1 SHALL move the FSM to CONFIRMA_PRESS and clear the counter; otherwise the FSM SHALL stay in SOLTO.
REQ-013 In CONFIRMA_PRESS, p=0 SHALL return the FSM to SOLTO with no pulse (bounce rejected); otherwise the counter SHALL increment.
REQ-014 In CONFIRMA_PRESS, when counter = DEBOUNCE_CICLOS-1 and p=1, the FSM SHALL enter PRESSIONADO, assert pulso for one cycle, and increment contagem.
REQ-015 In PRESSIONADO, p=0 SHALL move the FSM to CONFIRMA_SOLTURA and clear the counter; a held key SHALL produce no further pulses.
REQ-016 In CONFIRMA_SOLTURA, p=1 SHALL return the FSM to PRESSIONADO; when counter = DEBOUNCE_CICLOS-1 and p=0, the FSM SHALL enter SOLTO; no pulse SHALL be generated on release.
REQ-017 nivel SHALL be 1 exactly while the registered state is PRESSIONADO or CONFIRMA_SOLTURA.
REQ-018 Latency: with p stable pressed, pulso SHALL go high after rising edge DEBOUNCE_CICLOS+3, counting the first edge that samples the pressed input as edge 1.
REQ-019 All outputs SHALL be registered, with no combinational path from botao_bruto.
REQ-020 contagem SHALL wrap from 255 to 0 on the next confirmed press.
REQ-021 The debounce counter SHALL be $clog2(DEBOUNCE_CICLOS) bits wide and SHALL never exceed DEBOUNCE_CICLOS-1.
REQ-022 At most one pulso SHALL occur per SOLTO->PRESSIONADO round trip, and pulsos SHALL never be back-to-back.

Reset
REQ-023 Reset SHALL force state=SOLTO, counter=0, pulso=0, nivel=0, contagem=0.
REQ-024 Reset SHALL load both synchronizer flops with the released level (1 if ATIVO_BAIXO=1, else 0).
REQ-025 Reset asserted mid-confirmation, or with the key held, SHALL abort without a pulse.
REQ-026 After reset releases, a held key SHALL need a full new confirmation, exactly as in REQ-018.
REQ-027 Reset SHALL take priority over every transition in the same cycle.

Structure
REQ-028 A shared package condicionador_pkg SHALL hold the state-encoding typedef (2 bits) and the default constants DEBOUNCE_CICLOS_PADRAO=50000 and CONTAGEM_LARG=8.
REQ-029 One sub-module, sincronizador, SHALL implement the 2-flop synchronizer with a reset value parameter; the FSM and counters SHALL stay in the top module.

Verification (DEBOUNCE_CICLOS=4, ATIVO_BAIXO=1)
REQ-030 Clean press: botao_bruto 1->0 held 20 cycles -> pulso high for 1 cycle after edge 7, nivel=1, contagem=1.
REQ-031 Bounce: botao_bruto low 2 cycles, high 1, low 2, high -> pulso never asserted, nivel=0, contagem=0.
REQ-032 Hold then release with a 1-cycle glitch high during the hold -> single pulso, nivel stays 1, and nivel falls only after 4 stable high cycles plus 3 edges of latency.
REQ-033 Wrap: 256 clean press/release cycles -> contagem reads 0, and exactly 256 pulsos are counted by the bench.
REQ-034 Reset mid-confirmation: assert reset at edge 5 of a press while keeping the key held -> no pulso; after reset release, pulso comes 7 edges later and contagem=1.
REQ-035 Polarity: ATIVO_BAIXO=0, botao_bruto 0->1 held -> pulso after edge 7; the same stimulus inverted -> no pulso.
